// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//   Connects the fetch/execute pipeline to the branch predictor.
//   master : pipeline side. It drives the fetch lookup PC and the resolve bus,
//            and receives the prediction, mispredict, redirect and flush.
//   slave  : predictor side, with the opposite directions.
//   Signals:
//     fetch_pc_pi          lookup PC at fetch
//     predict_taken_po     combinational prediction for fetch_pc_pi
//     resolve_valid_pi     a branch resolves at execute this cycle
//     resolve_pc_pi        PC of the resolving branch
//     resolve_predicted_pi prediction the branch was fetched with
//     is_branch_taken_pi   actual outcome from the comparator
//     resolve_target_pi    branch target address
//     mispredict_po        one-cycle registered mispredict pulse
//     redirect_pc_po       corrected fetch PC, valid with mispredict_po
//     flush_po             squash younger instructions
//   The optional BRANCH_PRED_STATS_EN macro adds branch_count_po and
//   mispredict_count_po.
interface branch_predictor_if;
  logic [15:0] fetch_pc_pi;
  logic        predict_taken_po;
  logic        resolve_valid_pi;
  logic [15:0] resolve_pc_pi;
  logic        resolve_predicted_pi;
  logic        is_branch_taken_pi;
  logic [15:0] resolve_target_pi;
  logic        mispredict_po;
  logic [15:0] redirect_pc_po;
  logic        flush_po;
`ifdef BRANCH_PRED_STATS_EN
  logic [15:0] branch_count_po;
  logic [15:0] mispredict_count_po;
`endif

  modport master (
`ifdef BRANCH_PRED_STATS_EN
    input  branch_count_po,
    input  mispredict_count_po,
`endif
    output fetch_pc_pi,
    output resolve_valid_pi,
    output resolve_pc_pi,
    output resolve_predicted_pi,
    output is_branch_taken_pi,
    output resolve_target_pi,
    input  predict_taken_po,
    input  mispredict_po,
    input  redirect_pc_po,
    input  flush_po
  );

  modport slave (
`ifdef BRANCH_PRED_STATS_EN
    output branch_count_po,
    output mispredict_count_po,
`endif
    input  fetch_pc_pi,
    input  resolve_valid_pi,
    input  resolve_pc_pi,
    input  resolve_predicted_pi,
    input  is_branch_taken_pi,
    input  resolve_target_pi,
    output predict_taken_po,
    output mispredict_po,
    output redirect_pc_po,
    output flush_po
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
//   Bimodal predictor built from a table of 2-bit saturating counters that
//   are indexed by pc[INDEX_BITS-1:0].
//   - Lookup is combinational. predict_taken_po is counter[1] of the entry
//     that fetch_pc_pi selects.
//   - A resolution that arrives in IDLE trains its entry. When the carried
//     prediction differs from the actual outcome, the next edge raises a
//     one-cycle mispredict pulse and a redirect PC. flush_po then stays high
//     for FLUSH_CYCLES cycles.
//   - A resolution that arrives during a flush is wrong-path. It is ignored.
//   Ports:
//     clk_pi    clock
//     reset_pi  synchronous active-high reset. It sets every counter to 01.
//     bp_if     branch_predictor_if.slave (fetch lookup, resolve bus, outputs)
//   Parameters: INDEX_BITS (log2 of the entry count), FLUSH_CYCLES (1..7).
//   Optional: define BRANCH_PRED_STATS_EN to add branch_count_po and
//   mispredict_count_po.
module branch_predictor #(
  parameter int INDEX_BITS   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk_pi,
  input logic               reset_pi,
  branch_predictor_if.slave bp_if
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [1:0]  table_q [ENTRIES];
  logic        mispredict_q;
  logic [15:0] redirect_pc_q;

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] resolve_idx;
  logic                  accept;
  logic                  mispredict_event;
  logic [1:0]            ctr_cur;
  logic [1:0]            ctr_next;
  logic [15:0]           redirect_next;

  assign fetch_idx   = bp_if.fetch_pc_pi[INDEX_BITS-1:0];
  assign resolve_idx = bp_if.resolve_pc_pi[INDEX_BITS-1:0];

  // Only a resolution that arrives in IDLE is processed. A resolution during
  // FLUSH is wrong-path.
  assign accept           = bp_if.resolve_valid_pi && (state_q == IDLE);
  assign mispredict_event = accept &&
                            (bp_if.resolve_predicted_pi != bp_if.is_branch_taken_pi);

  // The lookup reads the registered table, so a same-cycle update to the same
  // index is not yet visible here.
  assign bp_if.predict_taken_po = table_q[fetch_idx][1];

  always_comb begin
    ctr_cur  = table_q[resolve_idx];
    ctr_next = ctr_cur;
    if (bp_if.is_branch_taken_pi) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  assign redirect_next = bp_if.is_branch_taken_pi ? bp_if.resolve_target_pi
                                                  : bp_if.resolve_pc_pi + 16'd1;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mispredict_event) begin
          state_d     = FLUSH;
          flush_cnt_d = 3'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q == 3'd1) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= 2'b01;
      end
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      if (accept) table_q[resolve_idx] <= ctr_next;
      mispredict_q <= mispredict_event;
      if (mispredict_event) redirect_pc_q <= redirect_next;
    end
  end

  assign bp_if.mispredict_po  = mispredict_q;
  assign bp_if.redirect_pc_po = redirect_pc_q;
  assign bp_if.flush_po       = (state_q == FLUSH);

`ifdef BRANCH_PRED_STATS_EN
  logic [15:0] branch_count_q;
  logic [15:0] mispredict_count_q;

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (accept)           branch_count_q     <= branch_count_q + 16'd1;
      if (mispredict_event) mispredict_count_q <= mispredict_count_q + 16'd1;
    end
  end

  assign bp_if.branch_count_po     = branch_count_q;
  assign bp_if.mispredict_count_po = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed and random stimulus for branch_predictor. A behavioural model
//   keeps an integer counter per entry and the number of flush cycles left.
module tb_branch_predictor;

  localparam int IDX_BITS = 4;
  localparam int ENTRIES  = 16;
  localparam int NFLUSH   = 2;

  logic clk_pi   = 1'b0;
  logic reset_pi = 1'b0;

  branch_predictor_if bp_if ();

  branch_predictor #(
    .INDEX_BITS   (IDX_BITS),
    .FLUSH_CYCLES (NFLUSH)
  ) dut (
    .clk_pi   (clk_pi),
    .reset_pi (reset_pi),
    .bp_if    (bp_if)
  );

  always #5 clk_pi = ~clk_pi;

  int checks = 0;
  int errors = 0;

  // Reference model
  int          m_ctr [ENTRIES];
  int          m_flush_left = 0;
  bit          m_valid_state = 1'b0;
  logic        m_mis = 1'b0;
  logic [15:0] m_redir = 16'h0000;
  int          m_bcnt = 0;
  int          m_mcnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_predict(input logic [15:0] pc);
    return m_ctr[pc % ENTRIES] >= 2;
  endfunction

  // One clock cycle: drive the inputs, check the lookup before the edge,
  // advance the model at the edge, then check the registered outputs.
  task automatic step(input bit rst, input bit v, input logic [15:0] pc,
                      input bit pred, input bit tk, input logic [15:0] tgt,
                      input logic [15:0] fpc);
    int idx;
    reset_pi                   = rst;
    bp_if.resolve_valid_pi     = v;
    bp_if.resolve_pc_pi        = pc;
    bp_if.resolve_predicted_pi = pred;
    bp_if.is_branch_taken_pi   = tk;
    bp_if.resolve_target_pi    = tgt;
    bp_if.fetch_pc_pi          = fpc;
    #1;
    if (m_valid_state)
      check("predict", 16'(bp_if.predict_taken_po), 16'(model_predict(fpc)));
    @(posedge clk_pi);
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
      m_flush_left  = 0;
      m_mis         = 1'b0;
      m_redir       = 16'h0000;
      m_bcnt        = 0;
      m_mcnt        = 0;
      m_valid_state = 1'b1;
    end else begin
      m_mis = 1'b0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (v) begin
        idx = pc % ENTRIES;
        m_bcnt++;
        if (tk) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        if (pred != tk) begin
          m_mis        = 1'b1;
          m_redir      = tk ? tgt : 16'((32'(pc) + 1) % 65536);
          m_flush_left = NFLUSH;
          m_mcnt++;
        end
      end
    end
    #1;
    check("mispredict", 16'(bp_if.mispredict_po), 16'(m_mis));
    check("redirect_pc", bp_if.redirect_pc_po, m_redir);
    check("flush", 16'(bp_if.flush_po), 16'(m_flush_left > 0));
`ifdef BRANCH_PRED_STATS_EN
    check("branch_count", bp_if.branch_count_po, 16'(m_bcnt % 65536));
    check("mispredict_count", bp_if.mispredict_count_po, 16'(m_mcnt % 65536));
`endif
  endtask

  task automatic idle(input logic [15:0] fpc);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, fpc);
  endtask

  // Resolves a branch using the prediction that the model holds for it.
  task automatic resolve_model(input logic [15:0] pc, input bit tk, input logic [15:0] tgt);
    step(1'b0, 1'b1, pc, model_predict(pc), tk, tgt, pc);
  endtask

  initial begin
    bp_if.fetch_pc_pi          = '0;
    bp_if.resolve_valid_pi     = 1'b0;
    bp_if.resolve_pc_pi        = '0;
    bp_if.resolve_predicted_pi = 1'b0;
    bp_if.is_branch_taken_pi   = 1'b0;
    bp_if.resolve_target_pi    = '0;
    @(negedge clk_pi);

    // Reset, then lookups across every index.
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0003);
    idle(16'h0003);
    for (int i = 0; i < ENTRIES; i++) begin
      idle(16'(i));
      check("predict_after_reset", 16'(bp_if.predict_taken_po), 16'h0000);
    end

    // Taken branch that was predicted not-taken, then the aliased lookup.
    step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'h0040, 16'h0015);
    check("redirect_target", bp_if.redirect_pc_po, 16'h0040);
    idle(16'h0015);
    idle(16'h0015);
    check("flush_ended", 16'(bp_if.flush_po), 16'h0000);
    idle(16'h0015);
    check("alias_predict", 16'(bp_if.predict_taken_po), 16'h0001);

    // Four correct not-taken resolutions, then four taken resolutions.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0100, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      resolve_model(16'h0002, 1'b1, 16'h0123);
      idle(16'h0002);
      idle(16'h0002);
    end
    check("saturated_taken", 16'(m_ctr[2]), 16'h0003);

    // Mispredict, then resolutions with opposite outcomes during both flush
    // cycles.
    step(1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0200, 16'h0007);
    step(1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0300, 16'h0007);
    step(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 16'h0400, 16'h0009);
    idle(16'h0007);
    idle(16'h0009);

    // Wrap of pc+1 from FFFF, then a reset during the first flush cycle.
    for (int i = 0; i < 3; i++) begin
      resolve_model(16'h000F, 1'b1, 16'h0500);
      idle(16'h000F);
      idle(16'h000F);
    end
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0600, 16'h000F);
    check("redirect_wrap", bp_if.redirect_pc_po, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h000F);
    check("flush_after_reset", 16'(bp_if.flush_po), 16'h0000);
    idle(16'h000F);

    // Three correct and two mispredicted resolutions, plus one wrong-path
    // resolution.
    resolve_model(16'h0001, 1'b0, 16'h0010);
    resolve_model(16'h0003, 1'b0, 16'h0011);
    resolve_model(16'h0004, 1'b0, 16'h0012);
    resolve_model(16'h0006, 1'b1, 16'h0013);
    step(1'b0, 1'b1, 16'h0006, 1'b1, 1'b1, 16'h0014, 16'h0006);
    idle(16'h0);
    resolve_model(16'h0008, 1'b1, 16'h0015);
    idle(16'h0);
    idle(16'h0);
`ifdef BRANCH_PRED_STATS_EN
    check("stats_branches", bp_if.branch_count_po, 16'd5);
    check("stats_mispredicts", bp_if.mispredict_count_po, 16'd2);
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] pc;
      bit          tk;
      bit          pred;
      pc   = 16'($urandom);
      tk   = 1'($urandom);
      pred = ($urandom_range(3) != 0) ? model_predict(pc) : 1'($urandom);
      step(($urandom_range(63) == 0), 1'($urandom), pc, pred, tk,
           16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
